// File: rtl/pwm_capture_nbit_pkg.sv
// Shared definitions for the PWM input capture unit: control SFR layout and
// a helper that builds the control-register hardware update words.
package pwm_capture_nbit_pkg;

  // Width of the defined part of the control SFR; upper bits are reserved.
  localparam int CAP_CTRL_W   = 11;

  // Bit positions inside the control SFR.
  localparam int CTRL_ON      = 0;
  localparam int CTRL_POL     = 1;
  localparam int CTRL_RST     = 2;
  localparam int CTRL_MODE    = 3;
  localparam int CTRL_PERC_EN = 4;
  localparam int CTRL_HIC_EN  = 5;
  localparam int CTRL_OVF_EN  = 6;
  localparam int CTRL_PERC_F  = 8;
  localparam int CTRL_HIC_F   = 9;
  localparam int CTRL_OVF_F   = 10;

  // Control SFR fields, LSB last. rst is hardware-cleared, *_f hardware-set.
  typedef struct packed {
    logic ovf_f;
    logic hic_f;
    logic perc_f;
    logic rsvd7;
    logic ovf_en;
    logic hic_en;
    logic perc_en;
    logic mode;
    logic rst;
    logic pol;
    logic on;
  } cap_ctrl_t;

  // Builds a control word carrying only the fields hardware may touch.
  function automatic cap_ctrl_t ctrl_flags(input logic rst_b, input logic perc_b,
                                           input logic hic_b, input logic ovf_b);
    cap_ctrl_t c;
    c        = '0;
    c.rst    = rst_b;
    c.perc_f = perc_b;
    c.hic_f  = hic_b;
    c.ovf_f  = ovf_b;
    return c;
  endfunction

endpackage

// File: rtl/pwm_capture_nbit_sync_edge_det.sv
// Input conditioning for capture/timer-gate inputs: multi-flop synchronizer,
// polarity inversion and registered single-cycle rise/fall pulses.
module cap_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clk_en,
  input  logic i_async,
  input  logic i_pol,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_lvl;

  // Synchronizer chain; r_sync[0] is the metastability-exposed stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else if (i_clk_en) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  // Polarity applied after synchronization so pol changes act like input edges.
  assign w_lvl = r_sync[SYNC_STAGES-1] ^ i_pol;

  // Edge detector with registered pulses, one cycle wide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_clk_en) begin
      r_prev <= w_lvl;
      r_rise <= w_lvl & ~r_prev;
      r_fall <= ~w_lvl & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/pwm_capture_nbit.sv
// PWM input capture: measures period (rise to rise) and high time (rise to
// fall) in clock cycles and publishes results through SFR hw_up/hw_val ports.
module pwm_capture_nbit
  import pwm_capture_nbit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sys_clk_en,
  input  logic                  pwm_in,
  input  logic [DATA_WIDTH-1:0] cap_ctrl,
  output logic [DATA_WIDTH-1:0] hw_up_cap_ctrl,
  output logic [DATA_WIDTH-1:0] hw_val_cap_ctrl,
  output logic [DATA_WIDTH-1:0] hw_up_cap_per,
  output logic [DATA_WIDTH-1:0] hw_val_cap_per,
  output logic [DATA_WIDTH-1:0] hw_up_cap_hi,
  output logic [DATA_WIDTH-1:0] hw_val_cap_hi,
  output logic                  per_cap_event,
  output logic                  hi_cap_event,
  output logic                  ovf_event
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RISE, S_HIGH, S_LOW, S_DONE
  } cap_state_e;

  cap_ctrl_t  w_ctrl;
  logic       w_unused_ctrl;
  logic       w_rise, w_fall, w_sat;
  logic       w_cap_hi, w_cap_per, w_ovf;
  logic [N-1:0] w_cnt_inc, w_cnt_next;
  cap_state_e w_state_next;

  cap_state_e r_state;
  logic [N-1:0] r_cnt, r_hval, r_pval;
  logic       r_hi_pulse, r_per_pulse, r_ovf_pulse, r_rst_up;

  assign w_ctrl        = cap_ctrl[CAP_CTRL_W-1:0];
  assign w_unused_ctrl = ^{cap_ctrl[DATA_WIDTH-1:CAP_CTRL_W], w_ctrl.rsvd7,
                           w_ctrl.perc_f, w_ctrl.hic_f, w_ctrl.ovf_f};

  cap_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_clk_en (sys_clk_en),
    .i_async  (pwm_in),
    .i_pol    (w_ctrl.pol),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_sat     = (r_cnt == '1);
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + N'(1);

  // Next state / counter; priority off > rst > edge > overflow.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cap_hi     = 1'b0;
    w_cap_per    = 1'b0;
    w_ovf        = 1'b0;
    if (!w_ctrl.on) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else if (w_ctrl.rst) begin
      w_state_next = S_WAIT_RISE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_WAIT_RISE;
          w_cnt_next   = '0;
        end
        S_WAIT_RISE: begin
          if (w_rise) begin
            w_state_next = S_HIGH;
            w_cnt_next   = N'(1);
          end else begin
            w_cnt_next   = '0;
          end
        end
        S_HIGH: begin
          if (w_rise) begin
            w_cnt_next   = N'(1);
          end else if (w_fall) begin
            w_state_next = S_LOW;
            w_cap_hi     = 1'b1;
            w_cnt_next   = w_cnt_inc;
          end else if (w_sat) begin
            w_ovf        = 1'b1;
            w_state_next = S_WAIT_RISE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_cap_per    = 1'b1;
            w_state_next = w_ctrl.mode ? S_DONE : S_HIGH;
            w_cnt_next   = w_ctrl.mode ? '0 : N'(1);
          end else if (w_sat) begin
            w_ovf        = 1'b1;
            w_state_next = S_WAIT_RISE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        S_DONE: begin
          w_cnt_next = '0;
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter, captured values and one-cycle publication pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hval      <= '0;
      r_pval      <= '0;
      r_hi_pulse  <= 1'b0;
      r_per_pulse <= 1'b0;
      r_ovf_pulse <= 1'b0;
      r_rst_up    <= 1'b0;
    end else if (sys_clk_en) begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      if (w_cap_hi)  r_hval <= r_cnt;
      if (w_cap_per) r_pval <= r_cnt;
      r_hi_pulse  <= w_cap_hi;
      r_per_pulse <= w_cap_per;
      r_ovf_pulse <= w_ovf;
      r_rst_up    <= w_ctrl.rst;
    end
  end

  // SFR update words: results sit in the low N bits, rest reads as zero.
  always_comb begin
    hw_up_cap_ctrl  = '0;
    hw_val_cap_ctrl = '0;
    hw_up_cap_per   = '0;
    hw_val_cap_per  = '0;
    hw_up_cap_hi    = '0;
    hw_val_cap_hi   = '0;
    hw_up_cap_ctrl[CAP_CTRL_W-1:0]  = ctrl_flags(r_rst_up, r_per_pulse, r_hi_pulse, r_ovf_pulse);
    hw_val_cap_ctrl[CAP_CTRL_W-1:0] = ctrl_flags(1'b0, r_per_pulse, r_hi_pulse, r_ovf_pulse);
    hw_up_cap_per[N-1:0]  = {N{r_per_pulse}};
    hw_val_cap_per[N-1:0] = r_pval;
    hw_up_cap_hi[N-1:0]   = {N{r_hi_pulse}};
    hw_val_cap_hi[N-1:0]  = r_hval;
  end

  assign per_cap_event = r_per_pulse & w_ctrl.perc_en;
  assign hi_cap_event  = r_hi_pulse  & w_ctrl.hic_en;
  assign ovf_event     = r_ovf_pulse & w_ctrl.ovf_en;

endmodule

// File: tb/tb_pwm_capture_nbit.sv
// Scoreboard bench for pwm_capture_nbit: stimulus pushes expected captures
// (value and cycle), a negedge monitor pops and compares each DUT output.
module tb_pwm_capture_nbit;
  import pwm_capture_nbit_pkg::*;

  localparam int K_HI = 0, K_PER = 1, K_OVF = 2, K_RST = 3;
  localparam int LAT  = 4;   // pwm_in edge to capture pulse, SYNC_STAGES+2
  localparam logic [31:0] FLAG_MASK = (32'd1 << CTRL_RST) | (32'd1 << CTRL_PERC_F) |
                                      (32'd1 << CTRL_HIC_F) | (32'd1 << CTRL_OVF_F);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clk_en, pwm_a, pwm_b;
  logic [31:0] ctrl_a, ctrl_b;
  logic [31:0] up_ctrl_a, val_ctrl_a, up_per_a, val_per_a, up_hi_a, val_hi_a;
  logic [31:0] up_ctrl_b, val_ctrl_b, up_per_b, val_per_b, up_hi_b, val_hi_b;
  logic        per_ev_a, hi_ev_a, ovf_ev_a, per_ev_b, hi_ev_b, ovf_ev_b;

  pwm_capture_nbit #(.DATA_WIDTH(32), .N(16), .SYNC_STAGES(2)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_clk_en(clk_en), .pwm_in(pwm_a),
    .cap_ctrl(ctrl_a), .hw_up_cap_ctrl(up_ctrl_a), .hw_val_cap_ctrl(val_ctrl_a),
    .hw_up_cap_per(up_per_a), .hw_val_cap_per(val_per_a),
    .hw_up_cap_hi(up_hi_a), .hw_val_cap_hi(val_hi_a),
    .per_cap_event(per_ev_a), .hi_cap_event(hi_ev_a), .ovf_event(ovf_ev_a));

  pwm_capture_nbit #(.DATA_WIDTH(32), .N(4), .SYNC_STAGES(2)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_clk_en(clk_en), .pwm_in(pwm_b),
    .cap_ctrl(ctrl_b), .hw_up_cap_ctrl(up_ctrl_b), .hw_val_cap_ctrl(val_ctrl_b),
    .hw_up_cap_per(up_per_b), .hw_val_cap_per(val_per_b),
    .hw_up_cap_hi(up_hi_b), .hw_val_cap_hi(val_hi_b),
    .per_cap_event(per_ev_b), .hi_cap_event(hi_ev_b), .ovf_event(ovf_ev_b));

  typedef struct { int dut; int kind; int val; longint cyc; } exp_t;
  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     en_seen = 1'b0;

  // Count enabled clock cycles; remember whether the last edge was enabled.
  always @(posedge clk) begin
    if (clk_en) cyc <= cyc + 1;
    en_seen <= clk_en;
  end

  function automatic string kname(input int k);
    case (k)
      K_HI:    return "HI";
      K_PER:   return "PER";
      K_OVF:   return "OVF";
      default: return "RST";
    endcase
  endfunction

  task automatic see(input int d, input int k, input int v, input bit ok);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected dut%0d %s val=%0d cyc=%0d, required none", d, kname(k), v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.kind != k || e.val != v || e.cyc != cyc || !ok) begin
        n_err++;
        $display("FAIL capture got dut%0d %s val=%0d cyc=%0d fields_ok=%0b, required dut%0d %s val=%0d cyc=%0d",
                 d, kname(k), v, cyc, ok, e.dut, kname(e.kind), e.val, e.cyc);
      end else begin
        $display("ok dut%0d %s val=%0d cyc=%0d", d, kname(k), v, cyc);
      end
    end
  endtask

  task automatic mon(input int d, input int n, input logic [31:0] upc, input logic [31:0] valc,
                     input logic [31:0] upp, input logic [31:0] valp, input logic [31:0] uph,
                     input logic [31:0] valh, input logic pe, input logic he, input logic oe);
    logic [31:0] m;
    bit          clean;
    m     = (32'd1 << n) - 32'd1;
    clean = ((upc & ~FLAG_MASK) == 32'd0);
    if (uph != 0 || he || upc[CTRL_HIC_F])
      see(d, K_HI, int'(valh & m), clean && uph == m && he && valc[CTRL_HIC_F] && (valh & ~m) == 0);
    if (upp != 0 || pe || upc[CTRL_PERC_F])
      see(d, K_PER, int'(valp & m), clean && upp == m && pe && valc[CTRL_PERC_F] && (valp & ~m) == 0);
    if (oe || upc[CTRL_OVF_F])
      see(d, K_OVF, 0, clean && oe && upc[CTRL_OVF_F] && valc[CTRL_OVF_F] && uph == 0 && upp == 0);
    if (upc[CTRL_RST])
      see(d, K_RST, 0, clean && !valc[CTRL_RST]);
  endtask

  // Monitor: examine outputs only after an enabled edge out of reset.
  always @(negedge clk) begin
    if (rst_n && en_seen) begin
      mon(0, 16, up_ctrl_a, val_ctrl_a, up_per_a, val_per_a, up_hi_a, val_hi_a, per_ev_a, hi_ev_a, ovf_ev_a);
      mon(1, 4,  up_ctrl_b, val_ctrl_b, up_per_b, val_per_b, up_hi_b, val_hi_b, per_ev_b, hi_ev_b, ovf_ev_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end else begin
      $display("ok %s = %0h", name, got);
    end
  endtask

  function automatic logic [31:0] cw(input bit on, input bit pol, input bit rst, input bit mode);
    logic [31:0] w;
    w = '0;
    w[CTRL_ON] = on; w[CTRL_POL] = pol; w[CTRL_RST] = rst; w[CTRL_MODE] = mode;
    w[CTRL_PERC_EN] = 1'b1; w[CTRL_HIC_EN] = 1'b1; w[CTRL_OVF_EN] = 1'b1;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv(input int d, input logic v);
    if (d == 0) pwm_a = v; else pwm_b = v;
  endtask

  task automatic push(input int d, input int k, input int v, input int lat);
    exp_t e;
    e.dut = d; e.kind = k; e.val = v; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // One pwm_in period: high for hi cycles then low for lo cycles.
  task automatic period(input int d, input int hi, input int lo,
                        input bit exp_per, input int pval, input bit exp_hi, input int hval);
    drv(d, 1'b1);
    if (exp_per) push(d, K_PER, pval, LAT);
    tick(hi);
    drv(d, 1'b0);
    if (exp_hi) push(d, K_HI, hval, LAT);
    tick(lo);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; pwm_a = 1'b0; pwm_b = 1'b0;
    ctrl_a = '0; ctrl_b = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_val_per", val_per_a, 32'd0);
    chk("reset_val_hi", val_hi_a, 32'd0);
    chk("reset_strobes", up_ctrl_a | val_ctrl_a | up_per_a | up_hi_a | up_ctrl_b | val_ctrl_b, 32'd0);
    chk("reset_events", {29'd0, per_ev_a, hi_ev_a, ovf_ev_a}, 32'd0);

    // Normal 3/5 waveform: first rise only aligns.
    ctrl_a = cw(1, 0, 0, 0); tick(3);
    for (int p = 0; p < 4; p++) period(0, 3, 5, p > 0, 8, 1'b1, 3);
    ctrl_a = cw(0, 0, 0, 0); tick(3);

    // Inverted polarity: internal rise is the pwm_in fall.
    ctrl_a = cw(0, 1, 0, 0); tick(5);
    ctrl_a = cw(1, 1, 0, 0); tick(3);
    for (int p = 0; p < 4; p++) begin
      drv(0, 1'b1); if (p > 0) push(0, K_HI, 5, LAT); tick(3);
      drv(0, 1'b0); if (p > 0) push(0, K_PER, 8, LAT); tick(5);
    end
    ctrl_a = cw(0, 1, 0, 0); tick(2);
    ctrl_a = cw(0, 0, 0, 0); tick(5);

    // Single-shot: one measurement, then DONE until rst.
    ctrl_a = cw(1, 0, 0, 1); tick(3);
    for (int p = 0; p < 4; p++) period(0, 3, 5, p == 1, 8, p == 0, 3);
    ctrl_a = cw(1, 0, 1, 1); push(0, K_RST, 0, 1); tick(1);
    ctrl_a = cw(1, 0, 0, 1); tick(3);
    for (int p = 0; p < 2; p++) period(0, 3, 5, p == 1, 8, p == 0, 3);
    ctrl_a = cw(0, 0, 0, 0); tick(3);

    // N=4 overflow: held high past saturation, then measurement restarts.
    ctrl_b = cw(1, 0, 0, 0); tick(3);
    drv(1, 1'b1); push(1, K_OVF, 0, LAT + 15); tick(20);
    drv(1, 1'b0); tick(5);
    for (int p = 0; p < 2; p++) period(1, 3, 5, p == 1, 8, 1'b1, 3);
    ctrl_b = cw(0, 0, 0, 0); tick(3);

    // Turn off mid-HIGH, back on while still high: partial period ignored.
    ctrl_a = cw(1, 0, 0, 0); tick(3);
    drv(0, 1'b1); tick(4);
    ctrl_a = cw(0, 0, 0, 0); tick(2);
    ctrl_a = cw(1, 0, 0, 0); tick(3);
    drv(0, 1'b0); tick(5);
    for (int p = 0; p < 2; p++) period(0, 3, 5, p == 1, 8, 1'b1, 3);
    ctrl_a = cw(0, 0, 0, 0); tick(3);

    // Clock enable low during HIGH freezes the count; then async reset mid-LOW.
    ctrl_a = cw(1, 0, 0, 0); tick(3);
    period(0, 3, 5, 1'b0, 0, 1'b1, 3);
    drv(0, 1'b1); push(0, K_PER, 8, LAT); tick(1);
    clk_en = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    clk_en = 1'b1; tick(2);
    drv(0, 1'b0); push(0, K_HI, 3, LAT); tick(5);
    period(0, 3, 5, 1'b1, 8, 1'b1, 3);
    chk("held_val_hi", val_hi_a, 32'd3);
    chk("held_val_per", val_per_a, 32'd8);
    rst_n = 1'b0; #2;
    chk("async_rst_val_hi", val_hi_a, 32'd0);
    chk("async_rst_val_per", val_per_a, 32'd0);
    chk("async_rst_strobes", up_ctrl_a | val_ctrl_a | up_per_a | up_hi_a, 32'd0);
    tick(3);
    rst_n = 1'b1;
    ctrl_a = cw(0, 0, 0, 0); tick(10);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d required=0 (next dut%0d %s val=%0d cyc=%0d)",
               sb.size(), sb[0].dut, kname(sb[0].kind), sb[0].val, sb[0].cyc);
    end else begin
      $display("ok scoreboard_drain pending=0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
